fft_sdf_stage_ctrl: RTL and testbench

//  Parametrised control unit for any radix-2 SDF (single-delay-feedback) DIF butterfly stage of an N-point FFT.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_pos_cnt.sv | 40 ++++
 rtl/fft_sdf_stage_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fft_sdf_stage_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared types and elaboration-time helpers for the radix-2 SDF stage
//   controller.
//   - state_e     : controller state (IDLE, FILL, RUN, DRAIN)
//   - delay_depth : delay-line depth D = 2**(LOG2N-1-STAGE)
//   - tw_width    : width of the twiddle index k of W_N^k (LOG2N-1)
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int delay_depth(input int log2n, input int stage);
    return 1 << (log2n - 1 - stage);
  endfunction

  function automatic int tw_width(input int log2n);
    return log2n - 1;
  endfunction

endpackage

// File: rtl/fft_pos_cnt.sv
// ---------------------------------------------------------------------------
// fft_pos_cnt
//   Wrapping W-bit position counter with synchronous clear and enable.
//   Clear is applied before the increment, so clr=1/en=1 in the same cycle
//   lands on 1 (the current item becomes position 0 and is counted).
// Ports
//   clk    in   clock
//   rst    in   asynchronous, active-high reset
//   en     in   count one item this cycle
//   clr    in   synchronous clear to zero
//   cnt_q  out  current count (wraps 2**W-1 -> 0)
// ---------------------------------------------------------------------------
module fft_pos_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt_q
);

  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    if (en) begin
      cnt_d = cnt_d + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fft_sdf_stage_ctrl
//   Control unit for one radix-2 SDF DIF butterfly stage of an N-point FFT
//   (N = 2**LOG2N, delay depth D = 2**(LOG2N-1-STAGE)). Tracks the sample
//   position, drives delay-line shift enable, butterfly/bypass select and
//   twiddle index, registers the data path into butterfly port A and flushes
//   the delay line with zero samples when a frame is not followed by another.
//   All outputs are registered (latency 1 from the accepted sample).
// Optional feature: define FFT_SDF_SOF_CHECK_EN to enable start-of-frame
//   checking with a sticky err_o; otherwise sof_i is ignored and err_o is 0.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   valid_i, sof_i            input sample valid, start-of-frame marker
//   data_in_r, data_in_i      input sample (signed, DW bits each)
//   valid_o                   stage output valid
//   sr_en                     delay-line shift enable
//   bf_sel                    1 = butterfly phase, 0 = fill/bypass phase
//   tw_idx                    twiddle index k (meaningful when bf_sel=1)
//   data_out_r, data_out_i    registered input sample, zero while flushing
//   frame_done                pulse with the output of sample N-1
//   err_o                     sticky framing error
// ---------------------------------------------------------------------------
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N = 5,
  parameter int STAGE = 0,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 sof_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic                 valid_o,
  output logic                 sr_en,
  output logic                 bf_sel,
  output logic [LOG2N-2:0]     tw_idx,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic                 frame_done,
  output logic                 err_o
);

  localparam int N    = 1 << LOG2N;
  localparam int D    = delay_depth(LOG2N, STAGE);
  localparam int TW_W = tw_width(LOG2N);

  localparam logic [LOG2N-1:0] D_V    = LOG2N'(D);
  localparam logic [LOG2N-1:0] D_LAST = LOG2N'(D - 1);
  localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] P_MASK = LOG2N'(2 * D - 1);

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  sr_en_q, sr_en_d;
  logic                  bf_sel_q, bf_sel_d;
  logic [TW_W-1:0]       tw_idx_q, tw_idx_d;
  logic signed [DW-1:0]  data_r_q, data_r_d;
  logic signed [DW-1:0]  data_i_q, data_i_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;

  logic [LOG2N-1:0] cnt_q, dcnt_q;
  logic             cnt_en, cnt_clr, dcnt_en, dcnt_clr;
  logic [LOG2N-1:0] cur_cnt, pos;
  logic             accept, resync, fill_smp;

`ifndef FFT_SDF_SOF_CHECK_EN
  logic sof_unused;
  assign sof_unused = sof_i;
`endif

  fft_pos_cnt #(.W(LOG2N)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt_q (cnt_q)
  );

  fft_pos_cnt #(.W(LOG2N)) u_dcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (dcnt_en),
    .clr   (dcnt_clr),
    .cnt_q (dcnt_q)
  );

  always_comb begin
    // NOTE: every variable gets a default here, so no path can infer a latch.
    state_d      = state_q;
    valid_d      = 1'b0;
    sr_en_d      = 1'b0;
    bf_sel_d     = bf_sel_q;
    tw_idx_d     = tw_idx_q;
    data_r_d     = data_r_q;
    data_i_d     = data_i_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    dcnt_en      = 1'b0;
    dcnt_clr     = 1'b0;
    accept       = 1'b0;
    resync       = 1'b0;
    cur_cnt      = cnt_q;
    pos          = '0;
    fill_smp     = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          accept = 1'b1;
`ifdef FFT_SDF_SOF_CHECK_EN
          if (!sof_i) err_d = 1'b1;
`endif
        end
      end
      FILL, RUN: begin
        if (valid_i) begin
          accept = 1'b1;
`ifdef FFT_SDF_SOF_CHECK_EN
          // Misplaced SOF: restart the frame with this sample as position 0.
          if (sof_i && (cnt_q != '0)) begin
            resync = 1'b1;
            err_d  = 1'b1;
          end
`endif
        end
      end
      DRAIN: begin
        if (valid_i && (dcnt_q == '0)) begin
          // Back-to-back frame: its samples push the old tail out instead.
          accept = 1'b1;
        end else begin
          valid_d  = 1'b1;
          sr_en_d  = 1'b1;
          bf_sel_d = 1'b0;
          tw_idx_d = '0;
          data_r_d = '0;
          data_i_d = '0;
          if (dcnt_q == D_LAST) begin
            dcnt_clr = 1'b1;
            state_d  = IDLE;
          end else begin
            dcnt_en = 1'b1;
          end
`ifdef FFT_SDF_SOF_CHECK_EN
          if (valid_i) err_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (resync) cur_cnt = '0;
      cnt_clr  = resync;
      cnt_en   = 1'b1;
      pos      = cur_cnt & P_MASK;
      sr_en_d  = 1'b1;
      data_r_d = data_in_r;
      data_i_d = data_in_i;
      bf_sel_d = (pos >= D_V);
      tw_idx_d = (pos >= D_V) ? TW_W'((pos - D_V) << STAGE) : '0;
      // Samples that only prime the delay line produce no output.
      fill_smp = (state_q == IDLE) || (state_q == FILL) || resync;
      if (fill_smp) begin
        state_d = (cur_cnt == D_LAST) ? RUN : FILL;
      end else begin
        valid_d = 1'b1;
        if (cur_cnt == N_LAST) begin
          frame_done_d = 1'b1;
          state_d      = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, so a reset drives every output to 0.
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      sr_en_q      <= 1'b0;
      bf_sel_q     <= 1'b0;
      tw_idx_q     <= '0;
      data_r_q     <= '0;
      data_i_q     <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      valid_q      <= valid_d;
      sr_en_q      <= sr_en_d;
      bf_sel_q     <= bf_sel_d;
      tw_idx_q     <= tw_idx_d;
      data_r_q     <= data_r_d;
      data_i_q     <= data_i_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign valid_o    = valid_q;
  assign sr_en      = sr_en_q;
  assign bf_sel     = bf_sel_q;
  assign tw_idx     = tw_idx_q;
  assign data_out_r = data_r_q;
  assign data_out_i = data_i_q;
  assign frame_done = frame_done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_sdf_stage_ctrl
//   Two stage controllers (LOG2N=5: STAGE=3 -> D=2, STAGE=0 -> D=16) share one
//   input stream. A frame-level reference model produces the expected
//   per-cycle control word and the expected data of every valid output; a
//   monitor compares them against the DUTs.
// ---------------------------------------------------------------------------
module tb_fft_sdf_stage_ctrl;

  localparam int LOG2N = 5;
  localparam int N     = 1 << LOG2N;
  localparam int DW    = 16;

`ifdef FFT_SDF_SOF_CHECK_EN
  localparam bit SOF_CHK = 1'b1;
`else
  localparam bit SOF_CHK = 1'b0;
`endif

  typedef struct packed {
    logic       sr_en;
    logic       valid;
    logic       fd;
    logic       bf;
    logic [3:0] tw;
    logic       err;
  } ctl_t;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } dat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic [DW-1:0] din_r = '0;
  logic [DW-1:0] din_i = '0;

  logic          valid_o [2];
  logic          sr_en [2];
  logic          bf_sel [2];
  logic [3:0]    tw_idx [2];
  logic [DW-1:0] dout_r [2];
  logic [DW-1:0] dout_i [2];
  logic          frame_done [2];
  logic          err_o [2];

  int total = 0;
  int bad   = 0;

  ctl_t ctl_q0[$], ctl_q1[$];
  dat_t dat_q0[$], dat_q1[$];

  // Reference model state, one slot per DUT.
  int         m_cnt [2];
  int         m_fill [2];
  int         m_drain [2];
  bit         m_act [2];
  bit         m_err [2];
  bit         m_bf [2];
  logic [3:0] m_tw [2];

  fft_sdf_stage_ctrl #(.LOG2N(LOG2N), .STAGE(3), .DW(DW)) u_dut_d2 (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .sof_i      (sof_i),
    .data_in_r  (din_r),
    .data_in_i  (din_i),
    .valid_o    (valid_o[0]),
    .sr_en      (sr_en[0]),
    .bf_sel     (bf_sel[0]),
    .tw_idx     (tw_idx[0]),
    .data_out_r (dout_r[0]),
    .data_out_i (dout_i[0]),
    .frame_done (frame_done[0]),
    .err_o      (err_o[0])
  );

  fft_sdf_stage_ctrl #(.LOG2N(LOG2N), .STAGE(0), .DW(DW)) u_dut_d16 (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .sof_i      (sof_i),
    .data_in_r  (din_r),
    .data_in_i  (din_i),
    .valid_o    (valid_o[1]),
    .sr_en      (sr_en[1]),
    .bf_sel     (bf_sel[1]),
    .tw_idx     (tw_idx[1]),
    .data_out_r (dout_r[1]),
    .data_out_i (dout_i[1]),
    .frame_done (frame_done[1]),
    .err_o      (err_o[1])
  );

  always #5 clk = ~clk;

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 16;
  endfunction

  function automatic int shf(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_fill[k] = 0; m_drain[k] = 0;
      m_act[k] = 1'b0; m_err[k] = 1'b0; m_bf[k] = 1'b0; m_tw[k] = '0;
    end
    ctl_q0.delete(); ctl_q1.delete(); dat_q0.delete(); dat_q1.delete();
  endtask

  // One input cycle of the frame-level reference: what the stage must show
  // after the next clock edge.
  task automatic model_step(input int k, input bit v, input bit s,
                            input logic [DW-1:0] r, input logic [DW-1:0] i);
    int   d, p;
    bit   acc, emit;
    ctl_t c;
    dat_t dd;
    d = dep(k); c = '0; dd = '0; acc = 1'b0; emit = 1'b0;
    if (m_drain[k] > 0) begin
      if (v && m_drain[k] == d) begin
        m_drain[k] = 0;
        acc = 1'b1;
      end else begin
        c.sr_en = 1'b1; c.valid = 1'b1; emit = 1'b1;
        m_bf[k] = 1'b0; m_tw[k] = '0;
        if (v && SOF_CHK) m_err[k] = 1'b1;
        m_drain[k]--;
        if (m_drain[k] == 0) m_act[k] = 1'b0;
      end
    end else if (v) begin
      acc = 1'b1;
      if (!m_act[k]) begin
        m_act[k] = 1'b1; m_cnt[k] = 0; m_fill[k] = d;
        if (SOF_CHK && !s) m_err[k] = 1'b1;
      end else if (SOF_CHK && s && m_cnt[k] != 0) begin
        m_err[k] = 1'b1; m_cnt[k] = 0; m_fill[k] = d;
      end
    end
    if (acc) begin
      p = m_cnt[k] % (2 * d);
      m_bf[k] = (p >= d);
      m_tw[k] = (p >= d) ? 4'((p - d) * (1 << shf(k))) : 4'd0;
      c.sr_en = 1'b1;
      if (m_fill[k] > 0) begin
        m_fill[k]--;
      end else begin
        c.valid = 1'b1; emit = 1'b1; dd = '{r: r, i: i};
        c.fd = (m_cnt[k] == N - 1);
      end
      if (m_cnt[k] == N - 1) m_drain[k] = d;
      m_cnt[k] = (m_cnt[k] + 1) % N;
    end
    c.bf = m_bf[k]; c.tw = m_tw[k]; c.err = m_err[k];
    if (k == 0) begin
      ctl_q0.push_back(c);
      if (emit) dat_q0.push_back(dd);
    end else begin
      ctl_q1.push_back(c);
      if (emit) dat_q1.push_back(dd);
    end
  endtask

  task automatic cycle(input bit v, input bit s, input logic [DW-1:0] r, input logic [DW-1:0] i);
    @(negedge clk);
    valid_i = v; sof_i = s; din_r = r; din_i = i;
    model_step(0, v, s, r, i);
    model_step(1, v, s, r, i);
  endtask

  task automatic send_frame(input int n, input bit sof_first);
    for (int j = 0; j < n; j++) begin
      cycle(1'b1, sof_first && (j == 0), DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      cycle(1'b0, 1'b0, DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; sof_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_step(0, 1'b0, 1'b0, din_r, din_i);
    model_step(1, 1'b0, 1'b0, din_r, din_i);
  endtask

  task automatic mon(input int k);
    ctl_t a, e;
    dat_t ad, ed;
    bit   have;
    a = '{sr_en: sr_en[k], valid: valid_o[k], fd: frame_done[k], bf: bf_sel[k],
          tw: tw_idx[k], err: err_o[k]};
    have = (k == 0) ? (ctl_q0.size() > 0) : (ctl_q1.size() > 0);
    if (!have) begin
      check("ctl_queue_underflow", 64'd1, 64'd0);
      return;
    end
    if (k == 0) e = ctl_q0.pop_front(); else e = ctl_q1.pop_front();
    check((k == 0) ? "ctl_d2" : "ctl_d16", 64'(a), 64'(e));
    if (valid_o[k]) begin
      ad = '{r: dout_r[k], i: dout_i[k]};
      have = (k == 0) ? (dat_q0.size() > 0) : (dat_q1.size() > 0);
      if (!have) begin
        check("unexpected_valid", 64'(ad), 64'hdead);
      end else begin
        if (k == 0) ed = dat_q0.pop_front(); else ed = dat_q1.pop_front();
        check((k == 0) ? "data_d2" : "data_d16", 64'(ad), 64'(ed));
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        check("reset_outputs",
              {22'd0, valid_o[k], sr_en[k], bf_sel[k], tw_idx[k], frame_done[k], err_o[k],
               dout_r[k], dout_i[k]}, 64'd0);
      end
    end else begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Reset in the middle of a frame, then a clean frame.
    send_frame(17, 1'b1);
    do_reset();
    send_frame(32, 1'b1);
    idle(20);

    // Single frame with full drain.
    send_frame(32, 1'b1);
    idle(20);

    // Two back-to-back frames.
    send_frame(32, 1'b1);
    send_frame(32, 1'b1);
    idle(20);

    // Three-cycle stall after sample 9.
    send_frame(10, 1'b1);
    idle(3);
    send_frame(22, 1'b0);
    idle(20);

    // Misplaced SOF at sample 12, then a complete restarted frame.
    send_frame(12, 1'b1);
    cycle(1'b1, 1'b1, DW'($urandom), DW'($urandom));
    send_frame(31, 1'b0);
    idle(20);

    // Randomised bursts with gaps, stray SOFs and valids during drain.
    do_reset();
    for (int b = 0; b < 8; b++) begin
      int len;
      len = $urandom_range(40, 90);
      for (int j = 0; j < len; j++) begin
        cycle($urandom_range(0, 99) < 80, ($urandom % 16) == 0, DW'($urandom), DW'($urandom));
      end
      idle($urandom_range(0, 20));
    end
    idle(40);

    @(posedge clk);
    #2;
    check("ctl_q0_left", 64'(ctl_q0.size()), 64'd0);
    check("ctl_q1_left", 64'(ctl_q1.size()), 64'd0);
    check("dat_q0_left", 64'(dat_q0.size()), 64'd0);
    check("dat_q1_left", 64'(dat_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
